prio_arbiter_8: RTL
===================

# prio_arbiter_8

Sequential 8-requester arbiter that shares one downstream resource using the team's fixed-priority rule: highest index wins, same as the 8-to-3 priority encoder. Grants are held while the owner keeps requesting. A hold-limit counter forces hand-over when others are waiting. Encoder-style status outputs (`gnt_vld`, `idle`) mirror the GS/EO convention, so it drops into designs already wired for the combinational encoder.

## Interface
- `MAX_HOLD`, 16: maximum consecutive grant cycles for one owner while others are waiting; legal range 2..256.
- `CNT_W`, `$clog2(MAX_HOLD)`: hold-counter width; derived, not overridden.

- `clk`  input  1  single clock; all state changes on rising edge.
- `rst_n`  input  1  synchronous, active-low reset.
- `en`  input  1  arbiter enable (EI analogue); low forces release and idle.
- `req`  input  8  request vector; `req[7]` highest priority.
- `gnt`  output  8  one-hot grant, registered; all-zero when no owner.
- `gnt_id`  output  3  binary index of owner; 0 when no owner.
- `gnt_vld`  output  1  1 while a grant is active (GS analogue).
- `idle`  output  1  registered `en & ~|req`: enabled with nothing pending (EO analogue).

## Operation
- States: IDLE (no owner), BUSY (owner = `gnt_id`). Hold counter `hcnt` (CNT_W bits) counts cycles spent with the current owner.
- IDLE:
  - `en & |req` -> BUSY; owner = highest set bit of `req`; `hcnt`=0.
  - Otherwise stay in IDLE.
- BUSY, evaluated in order each cycle:
  1. `!en`: -> IDLE, grant cleared, `hcnt`=0.
  2. `req[owner]==0` and other bits set: zero-bubble hand-over. New owner = highest set bit of `req`; `hcnt`=0; stay in BUSY.
  3. `req[owner]==0` and `req==0`: -> IDLE.
  4. `hcnt==MAX_HOLD-1` and `req & ~onehot(owner)` is nonzero: forced hand-over to the highest set bit of `req & ~onehot(owner)`; `hcnt`=0.
  5. Otherwise keep owner. `hcnt` increments, saturating at MAX_HOLD-1. Saturation covers the case where no other requester exists, so a lone owner is never pre-empted.
- `gnt == onehot(gnt_id)` when `gnt_vld`; `gnt==0`, `gnt_id==0` when not.
- Priority pick uses 8-to-3 encoding. An all-zero vector yields index 0 with valid=0, so all-zero input never produces a grant.
- Reset (`rst_n`=0 at an edge): state IDLE, `gnt`=0, `gnt_id`=0, `gnt_vld`=0, `idle`=0, `hcnt`=0. Reset mid-grant drops the grant on that edge, with no hand-over.

## Timing
- All outputs are registered. `req`/`en` sampled at edge N are reflected in `gnt`/`gnt_id`/`gnt_vld`/`idle` after edge N, i.e. 1-cycle latency.
- Hand-over is zero-bubble: the old owner's grant and the new owner's grant are on consecutive cycles, never both set, with no all-zero cycle between them.
- Owner holds at most MAX_HOLD consecutive cycles while another request is pending (`hcnt` 0..MAX_HOLD-1).
- `en` deassert: grant low one cycle later regardless of `hcnt`.
- Requesters must hold `req` until granted. Dropping `req` before grant is legal: the request is simply not served.
- Simultaneous owner release and new higher request: the new owner is picked from the current `req` by the normal priority rule.

## Structure
- Shared package `arb_pkg`:
  - state enum `{ARB_IDLE, ARB_BUSY}`
  - `localparam N_REQ = 8`
  - `localparam ID_W = 3`
- Sub-module `prio_pick_8`: combinational input [7:0] -> index [2:0] + valid.
  - Highest set bit wins; all-zero gives 0/0.
  - Instantiated twice: once on `req`, once on `req & ~onehot(owner)`.
- Top holds the FSM, hold counter and output registers.

## Test plan
- Reset then `en`=1, `req`=8'b0010_0100 → next cycle `gnt`=8'b0010_0000, `gnt_id`=5, `gnt_vld`=1, `idle`=0.
- Owner 5 drops `req[5]` while `req[2]`=1 → next cycle `gnt`=8'b0000_0100, `gnt_id`=2, with no all-zero cycle between.
- MAX_HOLD=4; `req[7]` and `req[1]` held high → `gnt_id`=7 for exactly 4 cycles, then 1 for 4 cycles, alternating.
- Lone `req[3]` held 40 cycles with MAX_HOLD=16 → `gnt_id`=3 continuously, never dropped.
- `en` low mid-grant → next cycle `gnt`=0, `gnt_vld`=0, `idle`=0. With `en`=1 and `req`=0 → `idle`=1 one cycle later.
- `rst_n`=0 for one edge during BUSY → all outputs 0 next cycle. With `req` still set after release → regrant 1 cycle after reset deasserts.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared types and helpers for the 8-requester fixed-priority arbiter.
package arb_pkg;
  localparam int N_REQ = 8;
  localparam int ID_W  = 3;

  typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_e;

  function automatic logic [N_REQ-1:0] onehot(input logic [ID_W-1:0] id);
    onehot     = '0;
    onehot[id] = 1'b1;
  endfunction
endpackage

// File: rtl/prio_pick_8.sv
// 8-to-3 priority pick: highest set bit wins; all-zero input gives index 0, valid 0.
module prio_pick_8
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] vec,
  output logic [ID_W-1:0]  index,
  output logic             valid
);
  always_comb begin
    index = '0;
    valid = |vec;
    // Ascending scan so the last (highest) set bit overrides lower ones.
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (vec[i]) index = ID_W'(i);
    end
  end
endmodule

// File: rtl/prio_arbiter_8.sv
// Fixed-priority 8-way arbiter with grant hold, zero-bubble hand-over and a
// hold limit that forces hand-over only when another requester is waiting.
module prio_arbiter_8
  import arb_pkg::*;
#(
  parameter  int MAX_HOLD = 16,
  localparam int CNT_W    = $clog2(MAX_HOLD)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [ID_W-1:0]  gnt_id,
  output logic             gnt_vld,
  output logic             idle
);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  arb_state_e       state;
  logic [CNT_W-1:0] hcnt;
  logic [N_REQ-1:0] others;
  logic [ID_W-1:0]  all_id;
  logic [ID_W-1:0]  oth_id;
  logic             all_vld;
  logic             oth_vld;

  // gnt is already onehot(owner) while busy and zero otherwise.
  assign others = req & ~gnt;

  prio_pick_8 u_pick_all (
    .vec   (req),
    .index (all_id),
    .valid (all_vld)
  );

  prio_pick_8 u_pick_other (
    .vec   (others),
    .index (oth_id),
    .valid (oth_vld)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ARB_IDLE;
      gnt     <= '0;
      gnt_id  <= '0;
      gnt_vld <= 1'b0;
      idle    <= 1'b0;
      hcnt    <= '0;
    end else begin
      idle <= en & ~|req;
      case (state)
        ARB_IDLE: begin
          if (en && all_vld) begin
            state   <= ARB_BUSY;
            gnt     <= onehot(all_id);
            gnt_id  <= all_id;
            gnt_vld <= 1'b1;
            hcnt    <= '0;
          end
        end
        ARB_BUSY: begin
          if (!en || (!req[gnt_id] && !all_vld)) begin
            state   <= ARB_IDLE;
            gnt     <= '0;
            gnt_id  <= '0;
            gnt_vld <= 1'b0;
            hcnt    <= '0;
          end else if (!req[gnt_id]) begin
            gnt    <= onehot(all_id);
            gnt_id <= all_id;
            hcnt   <= '0;
          end else if (hcnt == HOLD_LAST && oth_vld) begin
            gnt    <= onehot(oth_id);
            gnt_id <= oth_id;
            hcnt   <= '0;
          end else if (hcnt != HOLD_LAST) begin
            hcnt <= hcnt + CNT_W'(1);
          end
        end
        default: begin
          state   <= ARB_IDLE;
          gnt     <= '0;
          gnt_id  <= '0;
          gnt_vld <= 1'b0;
          hcnt    <= '0;
        end
      endcase
    end
  end
endmodule
